// File: rtl/cpu_clock_ctrl.sv
// Run/step/halt clock-enable sequencer for the Y86 core: emits a one-cycle cpu_en pulse
// at a programmable divide ratio. Define INSN_COUNT_EN to build the enable-pulse counter.
module cpu_clock_ctrl #(
  parameter int unsigned      DIV_W       = 28,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(4)
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_in,
  input  logic [DIV_W-1:0] div_value,
  output logic             cpu_en,
  output logic             cpu_clk_out,
  output logic [1:0]       state_out,
  output logic [31:0]      insn_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [DIV_W-1:0] w_div_sel, w_div_m1, w_div_half;
  logic             r_step_q, r_en, w_en_nxt, r_clk, w_clk_nxt;
  logic             w_step_edge, w_tick;

  assign w_step_edge = step_req & ~r_step_q;
  assign w_div_sel   = (div_value == '0) ? DEFAULT_DIV : div_value;
  assign w_div_m1    = r_div - DIV_W'(1);
  assign w_div_half  = r_div >> 1;
  assign w_tick      = (r_cnt == w_div_m1);

  // Every output is registered, so all decisions here land one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_div_nxt   = r_div;
    w_en_nxt    = 1'b0;
    w_clk_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (halt_in) begin
          w_state_nxt = ST_HALTED;
        end else if (run_req) begin
          w_state_nxt = ST_RUN;
          w_div_nxt   = w_div_sel;
        end else if (w_step_edge) begin
          w_state_nxt = ST_STEP;
          w_en_nxt    = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_in) begin
          w_state_nxt = ST_HALTED;
        end else if (!run_req) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = w_tick ? '0 : r_cnt + DIV_W'(1);
          w_en_nxt  = w_tick;
          w_clk_nxt = (r_cnt < w_div_half);
        end
      end
      ST_STEP:   w_state_nxt = ST_IDLE;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_div    <= DEFAULT_DIV;
      r_step_q <= 1'b0;
      r_en     <= 1'b0;
      r_clk    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_div    <= w_div_nxt;
      r_step_q <= step_req;
      r_en     <= w_en_nxt;
      r_clk    <= w_clk_nxt;
    end
  end

  assign cpu_en      = r_en;
  assign cpu_clk_out = r_clk;
  assign state_out   = r_state;

`ifdef INSN_COUNT_EN
  logic [31:0] r_insn;

  always_ff @(posedge clock_in) begin
    if (!reset_n)  r_insn <= '0;
    else if (r_en) r_insn <= r_insn + 32'd1;
  end

  assign insn_count = r_insn;
`else
  assign insn_count = 32'd0;
`endif

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
Run/step/halt controller that sequences the Y86 core's clock enable from the single board clock.
- Replaces free-running divided clocks with a registered one-cycle enable pulse `cpu_en` at a programmable divide ratio.
- Adds single-step and halt-on-HLT control so the core can be run, stepped from a button, or frozen for display.
- Sits between the board-level controls (switches and buttons) and every core register's clock enable.

Parameters:
DIV_W, 28, width of divide-ratio input and internal counter
DEFAULT_DIV, 28'd4, divide ratio used when div_value is 0

Ports:
clock_in  input  1  board clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset
run_req  input  1  level; 1 = free-run core
step_req  input  1  level from debounced button; rising edge = one step
halt_in  input  1  core has executed HLT / entered error state
div_value  input  DIV_W  divide ratio; sampled on entry to RUN
cpu_en  output  1  one-clock enable pulse to core registers
cpu_clk_out  output  1  ~50% duty visual clock for LED
state_out  output  2  00 IDLE, 01 RUN, 10 STEP, 11 HALTED
insn_count  output  32  enable-pulse count (see Optional Feature)

Behaviour:
- Reset (reset_n low at a rising edge) values:
  - state IDLE, cpu_en 0, cpu_clk_out 0.
  - Divide counter 0, step-edge history register 0.
  - insn_count 0, effective divisor D = DEFAULT_DIV.
  - Reset mid-RUN or mid-STEP aborts immediately; no cpu_en is issued in the cycle following reset.
- Effective divisor:
  - D = div_value, or DEFAULT_DIV if div_value == 0.
  - D is latched on the IDLE->RUN transition; changes to div_value while in RUN are ignored until the next entry to RUN.
- Step edge detect: `step_edge = step_req & ~step_q`, where step_q is step_req registered every cycle in every state.
- IDLE:
  - run_req=1 and halt_in=0 -> RUN; counter cleared to 0; D latched.
  - Otherwise step_edge=1 and halt_in=0 -> STEP.
  - run_req has priority; a coincident step edge is discarded.
  - halt_in=1 -> HALTED (takes priority over both).
- RUN:
  - Counter counts 0..D-1 and wraps to 0.
  - cpu_en is registered: high for exactly the one cycle after the edge where counter == D-1. First pulse appears D cycles after entering RUN; pulses repeat every D cycles. D=1 gives cpu_en high every cycle.
  - cpu_clk_out is registered `(counter < D/2)`. For D=1 it stays 0.
  - run_req=0 -> IDLE; counter cleared; no pulse issued on that edge even if counter == D-1.
  - halt_in=1 -> HALTED; it suppresses any pulse due on the same edge (halt wins over tick).
- STEP:
  - Entered with cpu_en registered 1, so exactly one pulse occurs, in the cycle after the detected edge.
  - Next edge -> IDLE unconditionally.
  - A held button gives no further steps; a new rising edge is required.
- HALTED:
  - cpu_en 0, cpu_clk_out 0.
  - run_req and step_req are ignored.
  - The only exit is reset.
- Outputs:
  - cpu_en and cpu_clk_out are 0 in IDLE and HALTED.
  - state_out reflects the registered state, with no combinational paths from inputs to outputs.
- Counter width DIV_W; no overflow is possible since the counter is bounded by D-1 ≤ 2^DIV_W-1.

Optional Feature:
Macro INSN_COUNT_EN.
- Defined: insn_count is a 32-bit register.
  - Increments by 1 in each cycle where cpu_en is high, wrapping 0xFFFFFFFF->0.
  - Cleared by reset only; retained across IDLE, RUN and HALTED.
- Not defined: no counter logic; insn_count is tied to 32'd0.

Test Plan:
1. Reset, then run_req=1 with div_value=4 -> state_out=01; first cpu_en 4 cycles after entry, then every 4 cycles; cpu_clk_out 1,1,0,0 pattern; with INSN_COUNT_EN, insn_count=5 after 5 pulses.
2. IDLE, step_req held high 20 cycles, low, then high again -> exactly two single-cycle cpu_en pulses, each one cycle after its rising edge; state_out returns to 00.
3. RUN with div_value=0 -> D=DEFAULT_DIV=4. Change div_value to 2 mid-run -> period stays 4. Drop run_req and re-raise -> period 2.
4. RUN with D=3, assert halt_in on the edge where counter==2 -> no cpu_en that cycle, state_out=11. Then toggle run_req and step_req -> no pulses. Reset -> state 00, cpu_en 0, insn_count 0.
5. IDLE with run_req rising and step_req rising on the same edge -> RUN entered, no STEP pulse. Also div_value=1 -> cpu_en high continuously, cpu_clk_out 0.
6. Assert reset_n low for one cycle mid-RUN, just before the counter==D-1 edge -> no pulse, all outputs at reset values; without INSN_COUNT_EN, insn_count stays 0 throughout.
